// File: rtl/rv32i_mem_pkg.sv
// Shared types and helpers for the RV32I M-stage data memory controller.
// Exports: memwrite_e (store size), loadsize_e (funct3 load size),
//          dmem_state_e (controller FSM), byte_en() (store byte-lane mask).
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_B    = 2'b01,
    MW_H    = 2'b10,
    MW_W    = 2'b11
  } memwrite_e;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } loadsize_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } dmem_state_e;

  // Byte-lane write mask. Halfword and word lanes ignore the low address
  // bits that would make them misaligned, giving natural-alignment truncation.
  function automatic logic [3:0] byte_en(input memwrite_e size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      MW_B:    be = 4'b0001 << a;
      MW_H:    be = 4'b0011 << {a[1], 1'b0};
      MW_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/rv32i_load_ext.sv
// Load lane select and sign/zero extension (purely combinational).
// Ports: word_i  raw 32-bit RAM word, addr_i byte offset, size_i load size,
//        data_o  extended load result for the writeback mux.
module rv32i_load_ext
  import rv32i_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  loadsize_e   size_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*addr_i +: 8];
    // Halfword uses only addr[1]; an odd offset is truncated to the even lane.
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      LS_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LS_BU:   data_o = {24'h0, byte_sel};
      LS_H:    data_o = {{16{half_sel[15]}}, half_sel};
      LS_HU:   data_o = {16'h0, half_sel};
      default: data_o = word_i;  // LW and any undefined funct3 code
    endcase
  end

endmodule

// File: rtl/rv32i_dmem_ctrl.sv
// RV32I M-stage data memory: word RAM with byte-lane stores, extended loads,
// and a WAIT_STATES-deep access that holds the pipeline through StallM.
// Ports: clk/rst (async active-low); M-stage request fields (ReqValidM, LoadM,
//        MemWriteM, LoadSizeM, ALUResultM, WriteDataM); results ReadDataM,
//        DoneM, StallM, MisalignM.
// Optional macro RV32I_DMEM_MISALIGN_CHK_EN: flag misaligned accesses instead
// of truncating them to natural alignment.
module rv32i_dmem_ctrl
  import rv32i_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqValidM,
  input  logic        LoadM,
  input  logic [1:0]  MemWriteM,
  input  logic [2:0]  LoadSizeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        DoneM,
  output logic        StallM,
  output logic        MisalignM
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_e        state_q, state_d;
  logic [3:0]         cnt_q;
  logic [IDX_W+1:0]   addr_q;
  logic [31:0]        wdata_q;
  memwrite_e          mw_q;
  loadsize_e          ls_q;
  logic               is_load_q;
  logic [31:0]        rword_q;
  logic [31:0]        hold_q;

  logic               req_active;
  logic               misalign_in;
  logic               mis_flag;
  logic               access_now;
  logic [31:0]        wdata_rep;
  logic [31:0]        ext_data;
  logic [31:0]        read_data;
  logic [3:0]         be;
  logic [IDX_W-1:0]   idx;
  memwrite_e          mw_in;

  logic [31:0] mem [DEPTH];

  // Upper address bits alias onto the RAM silently.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ALUResultM[31:IDX_W+2];

  assign mw_in      = memwrite_e'(MemWriteM);
  assign req_active = ReqValidM & (LoadM | (MemWriteM != 2'b00));
  assign access_now = (state_q == BUSY) && (cnt_q == 4'd0);
  assign idx        = addr_q[IDX_W+1:2];
  assign be         = byte_en(mw_q, addr_q[1:0]);

`ifdef RV32I_DMEM_MISALIGN_CHK_EN
  logic mis_q;

  always_comb begin
    misalign_in = 1'b0;
    if (MemWriteM != 2'b00) begin
      case (mw_in)
        MW_H:    misalign_in = ALUResultM[0];
        MW_W:    misalign_in = (ALUResultM[1:0] != 2'b00);
        default: misalign_in = 1'b0;
      endcase
    end else begin
      case (LoadSizeM)
        LS_B, LS_BU: misalign_in = 1'b0;
        LS_H, LS_HU: misalign_in = ALUResultM[0];
        default:     misalign_in = (ALUResultM[1:0] != 2'b00);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_q <= 1'b0;
    end else if ((state_q == IDLE) && req_active) begin
      mis_q <= misalign_in;
    end
  end

  assign mis_flag  = mis_q;
  assign MisalignM = (state_q == DONE) && mis_q;
`else
  assign misalign_in = 1'b0;
  assign mis_flag    = 1'b0;
  assign MisalignM   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state. A misaligned request skips BUSY so it never touches RAM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_active) state_d = misalign_in ? DONE : BUSY;
      BUSY: if (cnt_q == 4'd0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. StallM covers the accept cycle combinationally so the
  // pipeline freezes before the request registers are even loaded.
  always_comb begin
    StallM = 1'b0;
    DoneM  = 1'b0;
    case (state_q)
      IDLE:    StallM = req_active;
      BUSY:    StallM = 1'b1;
      DONE:    DoneM  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (mw_in)
      MW_B:    wdata_rep = {4{WriteDataM[7:0]}};
      MW_H:    wdata_rep = {2{WriteDataM[15:0]}};
      default: wdata_rep = WriteDataM;
    endcase
  end

  // Request capture, wait-state counter, registered RAM read, output hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      mw_q      <= MW_NONE;
      ls_q      <= LS_B;
      is_load_q <= 1'b0;
      rword_q   <= 32'h0;
      hold_q    <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_active) begin
            cnt_q     <= WAIT_STATES[3:0];
            addr_q    <= ALUResultM[IDX_W+1:0];
            wdata_q   <= wdata_rep;
            mw_q      <= mw_in;
            ls_q      <= loadsize_e'(LoadSizeM);
            is_load_q <= (MemWriteM == 2'b00);
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          else               rword_q <= mem[idx];
        end
        DONE:    hold_q <= read_data;
        default: ;
      endcase
    end
  end

  // RAM write port; contents are deliberately not reset. A reset before the
  // access edge forces IDLE, so an interrupted store never lands.
  always_ff @(posedge clk) begin
    if (access_now) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  rv32i_load_ext u_load_ext (
    .word_i (rword_q),
    .addr_i (addr_q[1:0]),
    .size_i (ls_q),
    .data_o (ext_data)
  );

  // Stores and flagged accesses return zero; outside DONE the last result holds.
  always_comb begin
    read_data = hold_q;
    if (state_q == DONE) read_data = (is_load_q && !mis_flag) ? ext_data : 32'h0;
  end

  assign ReadDataM = read_data;

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// Directed bench for rv32i_dmem_ctrl: one instance with WAIT_STATES=1 and one
// with WAIT_STATES=0 sharing the request fields, each with its own ReqValidM.
module tb_rv32i_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        rv0, rv1;
  logic        LoadM;
  logic [1:0]  MemWriteM;
  logic [2:0]  LoadSizeM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] rd0, rd1;
  logic        dn0, dn1, st0, st1, ms0, ms1;

  int checks = 0;
  int errors = 0;
  int done0_cnt = 0;

  int          lat, stalls;
  logic [31:0] rd;
  logic        mis;

  rv32i_dmem_ctrl #(.DEPTH(1024), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .ReqValidM(rv1), .LoadM(LoadM), .MemWriteM(MemWriteM),
    .LoadSizeM(LoadSizeM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(rd1), .DoneM(dn1), .StallM(st1), .MisalignM(ms1)
  );

  rv32i_dmem_ctrl #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .ReqValidM(rv0), .LoadM(LoadM), .MemWriteM(MemWriteM),
    .LoadSizeM(LoadSizeM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(rd0), .DoneM(dn0), .StallM(st0), .MisalignM(ms0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (dn0 === 1'b1) done0_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request (called just after a rising edge); returns just after
  // the edge that leaves DONE. lat = cycle index of DoneM, -1 on timeout.
  task automatic access(input int which, input bit keep, input logic ld,
                        input logic [1:0] mw, input logic [2:0] ls,
                        input logic [31:0] a, input logic [31:0] d,
                        output int o_lat, output int o_stalls,
                        output logic [31:0] o_rd, output logic o_mis);
    LoadM = ld; MemWriteM = mw; LoadSizeM = ls; ALUResultM = a; WriteDataM = d;
    if (which == 0) rv0 = 1'b1; else rv1 = 1'b1;
    o_lat = -1; o_stalls = 0; o_rd = 32'hx; o_mis = 1'bx;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((which == 0) ? st0 : st1) o_stalls++;
      if ((which == 0) ? dn0 : dn1) begin
        o_lat = k;
        o_rd  = (which == 0) ? rd0 : rd1;
        o_mis = (which == 0) ? ms0 : ms1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (!keep) begin rv0 = 1'b0; rv1 = 1'b0; end
  endtask

  initial begin
    rst = 1'b0; rv0 = 1'b0; rv1 = 1'b0; LoadM = 1'b0; MemWriteM = 2'b00;
    LoadSizeM = 3'b000; ALUResultM = 32'h0; WriteDataM = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'h0, st1}, 32'h0);
    chk("rst_done",  {31'h0, dn1}, 32'h0);
    chk("rst_rdata", rd1, 32'h0);
    chk("rst_mis",   {31'h0, ms1}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // SW then LW at 0x10, one wait state
    access(1, 0, 1'b0, 2'b11, 3'b010, 32'h10, 32'hDEADBEEF, lat, stalls, rd, mis);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_stalls", 32'(stalls), 32'd3);
    chk("sw_rdata", rd, 32'h0);
    access(1, 0, 1'b1, 2'b00, 3'b010, 32'h10, 32'h0, lat, stalls, rd, mis);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_stalls", 32'(stalls), 32'd3);
    chk("lw_data", rd, 32'hDEADBEEF);

    // Byte store into an existing word
    access(1, 0, 1'b0, 2'b11, 3'b010, 32'h10, 32'h11223344, lat, stalls, rd, mis);
    access(1, 0, 1'b0, 2'b01, 3'b000, 32'h13, 32'hABCDEF80, lat, stalls, rd, mis);
    access(1, 0, 1'b1, 2'b00, 3'b000, 32'h13, 32'h0, lat, stalls, rd, mis);
    chk("lb_13", rd, 32'hFFFFFF80);
    access(1, 0, 1'b1, 2'b00, 3'b100, 32'h13, 32'h0, lat, stalls, rd, mis);
    chk("lbu_13", rd, 32'h00000080);
    access(1, 0, 1'b1, 2'b00, 3'b010, 32'h10, 32'h0, lat, stalls, rd, mis);
    chk("lw_10_after_sb", rd, 32'h80223344);

    // ReadDataM holds while idle
    @(negedge clk);
    chk("rdata_hold", rd1, 32'h80223344);
    chk("idle_done", {31'h0, dn1}, 32'h0);
    @(posedge clk); #1;

    // Address wrap: 0x1010 aliases 0x10 with DEPTH=1024
    access(1, 0, 1'b1, 2'b00, 3'b010, 32'h1010, 32'h0, lat, stalls, rd, mis);
    chk("lw_wrap", rd, 32'h80223344);

    // Halfword store into upper half
    access(1, 0, 1'b0, 2'b11, 3'b010, 32'h20, 32'h55667788, lat, stalls, rd, mis);
    access(1, 0, 1'b0, 2'b10, 3'b001, 32'h22, 32'h1234ABCD, lat, stalls, rd, mis);
    access(1, 0, 1'b1, 2'b00, 3'b001, 32'h22, 32'h0, lat, stalls, rd, mis);
    chk("lh_22", rd, 32'hFFFFABCD);
    access(1, 0, 1'b1, 2'b00, 3'b101, 32'h22, 32'h0, lat, stalls, rd, mis);
    chk("lhu_22", rd, 32'h0000ABCD);
    access(1, 0, 1'b1, 2'b00, 3'b010, 32'h20, 32'h0, lat, stalls, rd, mis);
    chk("lw_20", rd, 32'hABCD7788);
    access(1, 0, 1'b1, 2'b00, 3'b000, 32'h20, 32'h0, lat, stalls, rd, mis);
    chk("lb_20", rd, 32'hFFFFFF88);
    access(1, 0, 1'b1, 2'b00, 3'b000, 32'h21, 32'h0, lat, stalls, rd, mis);
    chk("lb_21", rd, 32'h00000077);
    access(1, 0, 1'b1, 2'b00, 3'b001, 32'h20, 32'h0, lat, stalls, rd, mis);
    chk("lh_20", rd, 32'h00007788);

    // Undefined funct3 behaves as LW; misaligned word handling
    access(1, 0, 1'b0, 2'b11, 3'b010, 32'h40, 32'hCAFEF00D, lat, stalls, rd, mis);
    access(1, 0, 1'b1, 2'b00, 3'b011, 32'h40, 32'h0, lat, stalls, rd, mis);
    chk("ls_undef", rd, 32'hCAFEF00D);
    access(1, 0, 1'b1, 2'b00, 3'b010, 32'h41, 32'h0, lat, stalls, rd, mis);
`ifdef RV32I_DMEM_MISALIGN_CHK_EN
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_stalls", 32'(stalls), 32'd1);
    chk("mis_rdata", rd, 32'h0);
    chk("mis_flag", {31'h0, mis}, 32'h1);
    access(1, 0, 1'b0, 2'b11, 3'b010, 32'h42, 32'h01010101, lat, stalls, rd, mis);
    chk("mis_sw_flag", {31'h0, mis}, 32'h1);
    access(1, 0, 1'b1, 2'b00, 3'b010, 32'h40, 32'h0, lat, stalls, rd, mis);
    chk("mis_ram_unchanged", rd, 32'hCAFEF00D);
`else
    chk("trunc_lat", 32'(lat), 32'd3);
    chk("trunc_lw", rd, 32'hCAFEF00D);
    chk("trunc_flag", {31'h0, mis}, 32'h0);
    access(1, 0, 1'b1, 2'b00, 3'b001, 32'h43, 32'h0, lat, stalls, rd, mis);
    chk("trunc_lh", rd, 32'hFFFFCAFE);
`endif

    // Reset during BUSY of a store: outputs drop at once, store never lands
    LoadM = 1'b0; MemWriteM = 2'b11; LoadSizeM = 3'b010;
    ALUResultM = 32'h40; WriteDataM = 32'h0BADBEEF; rv1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_stall", {31'h0, st1}, 32'h1);
    #2;
    rv1 = 1'b0; rst = 1'b0;
    #1;
    chk("midrst_stall", {31'h0, st1}, 32'h0);
    chk("midrst_done",  {31'h0, dn1}, 32'h0);
    chk("midrst_rdata", rd1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    access(1, 0, 1'b1, 2'b00, 3'b010, 32'h40, 32'h0, lat, stalls, rd, mis);
    chk("midrst_old", rd, 32'hCAFEF00D);

    // Zero wait states, back-to-back SW/LW pairs with ReqValidM held high
    access(0, 1, 1'b0, 2'b11, 3'b010, 32'h100, 32'hA5A5A5A5, lat, stalls, rd, mis);
    chk("ws0_sw1_lat", 32'(lat), 32'd2);
    access(0, 1, 1'b1, 2'b00, 3'b010, 32'h100, 32'h0, lat, stalls, rd, mis);
    chk("ws0_lw1_lat", 32'(lat), 32'd2);
    chk("ws0_lw1", rd, 32'hA5A5A5A5);
    access(0, 1, 1'b0, 2'b11, 3'b010, 32'h104, 32'h13579BDF, lat, stalls, rd, mis);
    chk("ws0_sw2_lat", 32'(lat), 32'd2);
    access(0, 1, 1'b1, 2'b00, 3'b010, 32'h104, 32'h0, lat, stalls, rd, mis);
    chk("ws0_lw2", rd, 32'h13579BDF);
    access(0, 1, 1'b0, 2'b11, 3'b010, 32'h100, 32'h02468ACE, lat, stalls, rd, mis);
    access(0, 0, 1'b1, 2'b00, 3'b010, 32'h100, 32'h0, lat, stalls, rd, mis);
    chk("ws0_lw3_lat", 32'(lat), 32'd2);
    chk("ws0_lw3", rd, 32'h02468ACE);
    repeat (3) @(posedge clk);
    #1;
    chk("ws0_done_count", 32'(done0_cnt), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
